// File: rtl/fetch_pkg.sv
// Shared constants for the fetch-side queue.
// Opcode field and HALT/NOP encodings.
package fetch_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 11;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0800;
  localparam logic [4:0]         HALT_OPC  = 5'b00000;

  function automatic logic is_halt(
    input logic [OPC_HI-OPC_LO:0] opc
  );
    return opc == HALT_OPC;
  endfunction

endpackage

// File: rtl/fb_ctrl.sv
// Pointer, occupancy and halt-lock control.
// Produces both handshakes for the fetch buffer.
module fb_ctrl #(
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          out_ready,
  input  logic          flush,
  input  logic          in_halt,
  output logic          in_ready,
  output logic          out_valid,
  output logic          enq,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          halt_lock
);

  logic deq;

  assign in_ready  = (count < CW'(DEPTH))
                   && !halt_lock && !flush;
  assign out_valid = (count != '0) && !flush;
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      halt_lock <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      halt_lock <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      unique case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (enq && in_halt) halt_lock <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// Fetch-to-decode decoupling queue.
// Entry storage and head mux; control lives in fb_ctrl.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_instr,
  input  logic [DATA_W-1:0]        in_pc,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_instr,
  output logic [DATA_W-1:0]        out_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     halt_lock
);

  localparam int AW = $clog2(DEPTH);

  logic          enq;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic [DATA_W-1:0] mem_instr [DEPTH];
  logic [DATA_W-1:0] mem_pc    [DEPTH];

  fb_ctrl #(
    .DEPTH(DEPTH)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .out_ready(out_ready),
    .flush    (flush),
    .in_halt  (is_halt(in_instr[OPC_HI:OPC_LO])),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .enq      (enq),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .count    (count),
    .halt_lock(halt_lock)
  );

  always_ff @(posedge clk) begin
    if (enq) begin
      mem_instr[wr_ptr] <= in_instr;
      mem_pc[wr_ptr]    <= in_pc;
    end
  end

  // Empty queue shows a harmless bubble, not stale storage.
  always_comb begin
    out_instr = DATA_W'(NOP_INSTR);
    out_pc    = '0;
    if (count != '0) begin
      out_instr = mem_instr[rd_ptr];
      out_pc    = mem_pc[rd_ptr];
    end
  end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Decoupling queue directly downstream of the fetch stage. It captures each fetched instruction together with its PC+2 value, and presents them in order to decode through a valid/ready handshake. This absorbs decode stalls without re-fetching. The block also supports a branch/exception flush and stops accepting words after a HALT is enqueued.

## Interface
- `DATA_W`, 16, width of the instruction word and the PC
- `DEPTH`, 2, number of entries; must be a power of two and at least 2
- `clk`  in  1  rising-edge clock; the only clock
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  fetch presents a word this cycle
- `in_ready`  out  1  buffer accepts the word this cycle
- `in_instr`  in  DATA_W  fetched instruction
- `in_pc`  in  DATA_W  PC+2 of the fetched instruction
- `flush`  in  1  discard all entries (branch taken or exception)
- `out_valid`  out  1  head entry is valid for decode
- `out_ready`  in  1  decode consumes the head this cycle
- `out_instr`  out  DATA_W  head instruction; NOP (16'h0800) when empty
- `out_pc`  out  DATA_W  head PC+2; 0 when empty
- `count`  out  $clog2(DEPTH)+1  current occupancy
- `halt_lock`  out  1  a HALT word has been enqueued; intake is closed

## Operation
- Enqueue fires on `in_valid && in_ready`; dequeue fires on `out_valid && out_ready`.
- `in_ready` = (`count` < DEPTH) && !`halt_lock` && !`flush`. There is no combinational path from `out_ready`, so a full buffer does not accept a word in the cycle it drains.
- `out_valid` = (`count` != 0) && !`flush`.
- Storage is a circular array with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
- `count` updates as +1 on enqueue only, -1 on dequeue only, and unchanged when both or neither fire.
- Simultaneous enqueue and dequeue with `count` = 1 is legal: the old head leaves and the new word becomes the head.
- HALT detection: when an enqueued word has `in_instr[15:11]` == 5'b00000, `halt_lock` sets on the next edge. Words already queued still drain normally, and the HALT word itself is delivered to decode.
- Flush is synchronous and takes priority over everything else. On the edge where it is sampled:
  - both pointers and `count` go to 0;
  - `halt_lock` clears;
  - no enqueue or dequeue occurs, because both handshakes are masked during the flush cycle.
- While empty, outputs show NOP/0 so that decode sees a harmless bubble even if it ignores `out_valid`.

## Timing
- Reset state (asynchronous, `rst` low):
  - `count` = 0, pointers = 0, `halt_lock` = 0;
  - `out_valid` = 0, `in_ready` = 1 once `rst` deasserts;
  - `out_instr` = 16'h0800, `out_pc` = 0.
- If reset is asserted mid-operation, every entry is discarded immediately, without waiting for a clock edge.
- Latency: a word enqueued at edge N appears on `out_*` with `out_valid` = 1 after edge N. There is no bypass when the buffer is empty.
- Throughput is one word per cycle when `count` < DEPTH and decode consumes every cycle.
- `out_instr` and `out_pc` remain stable while `out_valid` && !`out_ready`.
- Storage is written only on enqueue. Entries need no reset, but the head mux must output NOP/0 when `count` = 0.

## Structure
- Shared package `fetch_pkg`:
  - `INSTR_W` = 16;
  - `NOP_INSTR` = 16'h0800;
  - `HALT_OPC` = 5'b00000;
  - the opcode field slice [15:11].
- One sub-module, `fb_ctrl`, holds the pointer, count and `halt_lock` registers and generates the handshake signals. The top level holds the entry array and the output mux.

## Test plan
- Reset, then fetch three words back-to-back with decode always ready: 16'hC001/16'h0002, 16'hC002/16'h0004, 16'hC003/16'h0006. Each word must appear exactly one cycle after entry, and `count` must never exceed 1.
- Hold `out_ready` = 0 and offer four words. Only the first two are accepted, `in_ready` drops once `count` = 2, and the head stays 16'hC001 throughout. Then release `out_ready`; words must drain in order with no loss or duplication.
- With `count` = 1, assert enqueue and dequeue in the same cycle. `count` must stay 1 and the new word must become the head. Run 10 cycles of this pattern to exercise pointer wrap-around.
- Assert `flush` with `count` = 2 and `in_valid` = 1. Both handshakes must be masked that cycle. On the next cycle `count` = 0 and the outputs read 16'h0800/0; the next word is accepted normally.
- Enqueue 16'h0000 (HALT). `halt_lock` rises, `in_ready` stays 0 with `in_valid` held, and HALT is still delivered to decode. A subsequent `flush` clears the lock and reopens intake.
- Drop `rst` mid-stream between clock edges. Outputs must show empty/NOP at once, and `in_ready` = 1 on the first edge after release.
